acc_multicycle_ctrl: RTL and testbench
======================================

# acc_multicycle_ctrl

Parametrised multicycle control unit for the accumulator CPU; successor to the fixed-width control FSM. It sequences fetch, decode, execute and memory states, and drives all datapath mux selects and write enables. Relative to the fixed FSM it adds three things: a memory ready/wait handshake with timeout, internal branch resolution from the ALU zero flag, and illegal-opcode trap and halt handling.

## Interface
- OPCODE_W, 6: opcode width. Must be ≥5.
- MEM_WAIT_EN, 1: when 1, memory states honour MemReady. When 0, MemReady is treated as constant 1.
- MAX_WAIT, 15: maximum stall cycles per memory access before trap. Range 1..255.
- CLK  in  1  clock; all state updates on the rising edge.
- Reset  in  1  reset Reset, asynchronous, active-high; clock CLK.
- Opcode  in  OPCODE_W  IR opcode field; valid from DECODE onward.
- MemReady  in  1  memory completes the current access this cycle.
- AluZero  in  1  ALU result == 0; combinational from the current-cycle ALU.
- PCSrc  out  2  0 = ALU, 1 = jump target, 2 = TRAP_VECTOR.
- PCWrite, IRWrite, ACCWrite, SPWrite, MemWrite, MemRead  out  1 each  enables.
- MemAddr  out  2  0 = PC, 1 = IR address, 2 = SP, 3 = ALUOut.
- MemData  out  1  0 = ACC, 1 = PC.
- ACCSrc  out  3  0 = upper imm, 1 = mem, 2 = MDR, 3 = imm, 4 = ALUOut.
- ALUSrcA  out  2  0 = PC, 1 = ACC, 2 = SP.
- ALUSrcB  out  3  0 = +2, 1 = sext imm, 2 = MDR, 3 = zext imm, 4 = branch offset.
- ALUOp  out  3  0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT.
- Trap  out  1  one-cycle pulse in TRAP.
- Halted  out  1  high in HALT.
- StateOut  out  5  current state code, for debug.

## Operation
- Opcodes: 0 HALT, 1 SAVE, 2 LOAD, 3 LOADUI, 4 BNE, 5 BEQ, 6 SLT, 7 SLTI, 8 J, 9 JAL, 10 SW, 11 LW, 12 MS, 13 SUB, 14 ADD, 15 ADDI, 16 AND, 17 OR, 18 ORI, 19 LOADI. Opcodes ≥20 go to TRAP.
- State flow:
  - FETCH → DECODE → execute state → FETCH.
  - SW and LW go through ADDR (ALUSrcA = 2, ALUSrcB = 1, ADD) before their memory state. SW → SW_MEM; LW → LW_MEM.
  - HALT state is absorbing.
- FETCH: MemRead = 1, MemAddr = 0, ALUSrcA = 0, ALUSrcB = 0, ADD, PCSrc = 0. IRWrite and PCWrite are asserted only in the cycle MemReady = 1.
- DECODE: ALUSrcA = 0, ALUSrcB = 4, ADD (branch target precompute). No enables.
- Memory states: FETCH, LOAD (MemAddr 1), SAVE (write, MemAddr 1, MemData 0), JAL (write, MemAddr 2, MemData 1, PCSrc 1), LW_MEM (MemAddr 3, ACCSrc 2), SW_MEM (write, MemAddr 3, MemData 0).
  - Each holds in place until MemReady = 1; all outputs are stable while held.
  - Side enables (PCWrite/ACCWrite/IRWrite) fire only in the ready cycle.
  - MemWrite/MemRead stay high throughout the hold.
- ALU states (SLT/SLTI/SUB/ADD/ADDI/AND/OR/ORI): ALUSrcA = 1; ALUSrcB = 2 (reg forms), 1 (ADDI/ADD-imm) or 3 (ORI/SLTI); the ALUOp from the opcode table; ACCWrite = 1, ACCSrc = 4.
- LOADUI: ACCSrc 0. LOADI: ACCSrc 3. Both with ACCWrite.
- MS: SPWrite, ALUSrcA 2, ALUSrcB 1, ADD.
- J: PCWrite, PCSrc 1.
- BEQ/BNE: ALUSrcA 1, ALUSrcB 2, SUB, PCSrc 1. PCWrite = AluZero for BEQ, ~AluZero for BNE; this is resolved internally.
- Wait counter: 8 bits, cleared on entry to every memory state, incremented on each cycle with MemReady = 0.
  - If the counter equals MAX_WAIT and MemReady = 0, the next state is TRAP; no enables fire.
  - MemReady = 1 in the same cycle the counter reaches MAX_WAIT completes the access normally.
- TRAP: PCSrc 2, PCWrite 1, Trap 1 → FETCH.
- HALT: all enables 0, Halted 1. Exited only by Reset.
- Unused selects drive 0. No don't-cares.

## Timing
- Reset (asynchronous) forces state FETCH, clears the wait counter, and takes Trap/Halted low. While Reset is high, all enables are gated to 0.
- Zero-wait latencies:
  - ALU, LOADI, LOADUI, J, branch, MS, HALT entry: 3 cycles.
  - LOAD, SAVE, JAL: 3 cycles.
  - LW, SW: 4 cycles.
- Each wait cycle adds 1 cycle per stall.
- Worst case per access is MAX_WAIT + 1 cycles, then TRAP.
- Outputs are Moore-decoded from state; the only Mealy terms are MemReady and AluZero gating of enables.
- Reset asserted mid-access drops MemWrite immediately.

## Structure
- Package acc_ctrl_pkg holds:
  - opcode localparams and the state enum (5-bit codes);
  - the ALUOp, ACCSrc, MemAddr, ALUSrcA/B and PCSrc encodings;
  - TRAP-vector select code.
- Sub-module acc_wait_timer: clear, incr and MAX_WAIT compare, producing a timeout flag. It is instantiated once.

## Test plan
- Reset, then ADD (14) with MemReady tied 1: StateOut goes FETCH → DECODE → ADD → FETCH. ACCWrite = 1 and ACCSrc = 4 only in cycle 3. No Trap.
- LW (11), MemReady low for 3 cycles in LW_MEM: state holds for 4 cycles and ACCWrite pulses once on the ready cycle. SW (10) reaches SW_MEM with MemWrite = 1.
- BEQ with AluZero = 1 gives PCWrite = 1, PCSrc = 1. BEQ with AluZero = 0 gives PCWrite = 0. BNE behaves inversely.
- Opcode 25: DECODE → TRAP, Trap = 1 for one cycle, PCSrc = 2 with PCWrite, then FETCH.
- MAX_WAIT = 3, FETCH with MemReady held 0: TRAP after 4 cycles with IRWrite never asserted. Repeat with MemReady rising on the 4th cycle: normal DECODE follows.
- HALT (0): Halted stays 1 for 20 cycles regardless of inputs. Asserting Reset mid-SAVE drops MemWrite the same cycle and returns to FETCH.

Source files
------------

// File: rtl/acc_ctrl_pkg.sv
// Shared encodings for the accumulator CPU multicycle controller: opcodes,
// state codes and datapath select values.
package acc_ctrl_pkg;

  localparam int unsigned OP_HALT   = 0;
  localparam int unsigned OP_SAVE   = 1;
  localparam int unsigned OP_LOAD   = 2;
  localparam int unsigned OP_LOADUI = 3;
  localparam int unsigned OP_BNE    = 4;
  localparam int unsigned OP_BEQ    = 5;
  localparam int unsigned OP_SLT    = 6;
  localparam int unsigned OP_SLTI   = 7;
  localparam int unsigned OP_J      = 8;
  localparam int unsigned OP_JAL    = 9;
  localparam int unsigned OP_SW     = 10;
  localparam int unsigned OP_LW     = 11;
  localparam int unsigned OP_MS     = 12;
  localparam int unsigned OP_SUB    = 13;
  localparam int unsigned OP_ADD    = 14;
  localparam int unsigned OP_ADDI   = 15;
  localparam int unsigned OP_AND    = 16;
  localparam int unsigned OP_OR     = 17;
  localparam int unsigned OP_ORI    = 18;
  localparam int unsigned OP_LOADI  = 19;

  typedef enum logic [4:0] {
    S_FETCH  = 5'd0,
    S_DECODE = 5'd1,
    S_HALT   = 5'd2,
    S_SAVE   = 5'd3,
    S_LOAD   = 5'd4,
    S_LOADUI = 5'd5,
    S_BNE    = 5'd6,
    S_BEQ    = 5'd7,
    S_SLT    = 5'd8,
    S_SLTI   = 5'd9,
    S_J      = 5'd10,
    S_JAL    = 5'd11,
    S_ADDR   = 5'd12,
    S_SW_MEM = 5'd13,
    S_LW_MEM = 5'd14,
    S_MS     = 5'd15,
    S_SUB    = 5'd16,
    S_ADD    = 5'd17,
    S_ADDI   = 5'd18,
    S_AND    = 5'd19,
    S_OR     = 5'd20,
    S_ORI    = 5'd21,
    S_LOADI  = 5'd22,
    S_TRAP   = 5'd23
  } state_t;

  typedef enum logic [2:0] {
    ALU_AND = 3'd0, ALU_OR = 3'd1, ALU_ADD = 3'd2, ALU_SUB = 3'd3, ALU_SLT = 3'd4
  } alu_op_t;

  typedef enum logic [2:0] {
    ACC_UPPER = 3'd0, ACC_MEM = 3'd1, ACC_MDR = 3'd2, ACC_IMM = 3'd3, ACC_ALU = 3'd4
  } acc_src_t;

  typedef enum logic [1:0] {
    MA_PC = 2'd0, MA_IR = 2'd1, MA_SP = 2'd2, MA_ALU = 2'd3
  } mem_addr_t;

  typedef enum logic {
    MD_ACC = 1'b0, MD_PC = 1'b1
  } mem_data_t;

  typedef enum logic [1:0] {
    SA_PC = 2'd0, SA_ACC = 2'd1, SA_SP = 2'd2
  } src_a_t;

  typedef enum logic [2:0] {
    SB_TWO = 3'd0, SB_SEXT = 3'd1, SB_MDR = 3'd2, SB_ZEXT = 3'd3, SB_BOFF = 3'd4
  } src_b_t;

  typedef enum logic [1:0] {
    PC_ALU = 2'd0, PC_JUMP = 2'd1, PC_TRAP = 2'd2
  } pc_src_t;

  localparam pc_src_t TRAP_VECTOR_SEL = PC_TRAP;

  // Execute state entered from DECODE; anything past LOADI is illegal.
  function automatic state_t exec_state(input logic [31:0] op);
    case (op)
      OP_HALT:   return S_HALT;
      OP_SAVE:   return S_SAVE;
      OP_LOAD:   return S_LOAD;
      OP_LOADUI: return S_LOADUI;
      OP_BNE:    return S_BNE;
      OP_BEQ:    return S_BEQ;
      OP_SLT:    return S_SLT;
      OP_SLTI:   return S_SLTI;
      OP_J:      return S_J;
      OP_JAL:    return S_JAL;
      OP_SW:     return S_ADDR;
      OP_LW:     return S_ADDR;
      OP_MS:     return S_MS;
      OP_SUB:    return S_SUB;
      OP_ADD:    return S_ADD;
      OP_ADDI:   return S_ADDI;
      OP_AND:    return S_AND;
      OP_OR:     return S_OR;
      OP_ORI:    return S_ORI;
      OP_LOADI:  return S_LOADI;
      default:   return S_TRAP;
    endcase
  endfunction

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_LOAD) || (s == S_SAVE) ||
           (s == S_JAL) || (s == S_LW_MEM) || (s == S_SW_MEM);
  endfunction

endpackage

// File: rtl/acc_wait_timer.sv
// Memory stall counter: counts not-ready cycles of one access and flags
// when the count has reached the configured limit.
module acc_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic CLK,
  input  logic Reset,
  input  logic clr,
  input  logic incr,
  output logic timeout
);

  localparam logic [7:0] LIMIT = 8'(MAX_WAIT);

  logic [7:0] cnt;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (incr && (cnt != 8'hFF)) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign timeout = (cnt == LIMIT);

endmodule

// File: rtl/acc_multicycle_ctrl.sv
// Multicycle control FSM for the accumulator CPU with memory wait/timeout,
// internal branch resolution and illegal-opcode trap/halt.
module acc_multicycle_ctrl
  import acc_ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int MAX_WAIT    = 15
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                MemReady,
  input  logic                AluZero,
  output logic [1:0]          PCSrc,
  output logic                PCWrite,
  output logic                IRWrite,
  output logic                ACCWrite,
  output logic                SPWrite,
  output logic                MemWrite,
  output logic                MemRead,
  output logic [1:0]          MemAddr,
  output logic                MemData,
  output logic [2:0]          ACCSrc,
  output logic [1:0]          ALUSrcA,
  output logic [2:0]          ALUSrcB,
  output logic [2:0]          ALUOp,
  output logic                Trap,
  output logic                Halted,
  output logic [4:0]          StateOut
);

  state_t    state, state_nxt;
  pc_src_t   pc_src;
  mem_addr_t mem_addr;
  mem_data_t mem_data;
  acc_src_t  acc_src;
  src_a_t    alu_a;
  src_b_t    alu_b;
  alu_op_t   alu_op;
  logic      pc_we, ir_we, acc_we, sp_we, mem_we, mem_re;
  logic      trap, halted, mem_state, ready;
  logic      wait_clr, wait_incr, wait_timeout;
  logic [31:0] op_ext;

  assign ready  = MEM_WAIT_EN ? MemReady : 1'b1;
  assign op_ext = 32'(Opcode);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pc_src    = PC_ALU;
    mem_addr  = MA_PC;
    mem_data  = MD_ACC;
    acc_src   = ACC_UPPER;
    alu_a     = SA_PC;
    alu_b     = SB_TWO;
    alu_op    = ALU_AND;
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    acc_we    = 1'b0;
    sp_we     = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    trap      = 1'b0;
    halted    = 1'b0;
    mem_state = is_mem_state(state);

    unique case (state)
      S_FETCH: begin
        mem_re    = 1'b1;
        alu_op    = ALU_ADD;
        ir_we     = ready;
        pc_we     = ready;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        alu_b     = SB_BOFF;
        alu_op    = ALU_ADD;
        state_nxt = exec_state(op_ext);
      end
      S_HALT: begin
        halted    = 1'b1;
        state_nxt = S_HALT;
      end
      S_SAVE: begin
        mem_we    = 1'b1;
        mem_addr  = MA_IR;
        state_nxt = S_FETCH;
      end
      S_LOAD: begin
        mem_re    = 1'b1;
        mem_addr  = MA_IR;
        acc_src   = ACC_MEM;
        acc_we    = ready;
        state_nxt = S_FETCH;
      end
      S_JAL: begin
        mem_we    = 1'b1;
        mem_addr  = MA_SP;
        mem_data  = MD_PC;
        pc_src    = PC_JUMP;
        pc_we     = ready;
        state_nxt = S_FETCH;
      end
      S_ADDR: begin
        alu_a     = SA_SP;
        alu_b     = SB_SEXT;
        alu_op    = ALU_ADD;
        state_nxt = (op_ext == OP_LW) ? S_LW_MEM : S_SW_MEM;
      end
      S_LW_MEM: begin
        mem_re    = 1'b1;
        mem_addr  = MA_ALU;
        acc_src   = ACC_MDR;
        acc_we    = ready;
        state_nxt = S_FETCH;
      end
      S_SW_MEM: begin
        mem_we    = 1'b1;
        mem_addr  = MA_ALU;
        state_nxt = S_FETCH;
      end
      S_LOADUI: begin
        acc_we    = 1'b1;
        acc_src   = ACC_UPPER;
        state_nxt = S_FETCH;
      end
      S_LOADI: begin
        acc_we    = 1'b1;
        acc_src   = ACC_IMM;
        state_nxt = S_FETCH;
      end
      S_MS: begin
        sp_we     = 1'b1;
        alu_a     = SA_SP;
        alu_b     = SB_SEXT;
        alu_op    = ALU_ADD;
        state_nxt = S_FETCH;
      end
      S_J: begin
        pc_we     = 1'b1;
        pc_src    = PC_JUMP;
        state_nxt = S_FETCH;
      end
      S_BEQ, S_BNE: begin
        alu_a     = SA_ACC;
        alu_b     = SB_MDR;
        alu_op    = ALU_SUB;
        pc_src    = PC_JUMP;
        pc_we     = (state == S_BEQ) ? AluZero : ~AluZero;
        state_nxt = S_FETCH;
      end
      S_SLT, S_SLTI, S_SUB, S_ADD, S_ADDI, S_AND, S_OR, S_ORI: begin
        alu_a     = SA_ACC;
        acc_we    = 1'b1;
        acc_src   = ACC_ALU;
        state_nxt = S_FETCH;
        unique case (state)
          S_SLT:   begin alu_b = SB_MDR;  alu_op = ALU_SLT; end
          S_SLTI:  begin alu_b = SB_ZEXT; alu_op = ALU_SLT; end
          S_SUB:   begin alu_b = SB_MDR;  alu_op = ALU_SUB; end
          S_ADD:   begin alu_b = SB_MDR;  alu_op = ALU_ADD; end
          S_ADDI:  begin alu_b = SB_SEXT; alu_op = ALU_ADD; end
          S_AND:   begin alu_b = SB_MDR;  alu_op = ALU_AND; end
          S_OR:    begin alu_b = SB_MDR;  alu_op = ALU_OR;  end
          default: begin alu_b = SB_ZEXT; alu_op = ALU_OR;  end
        endcase
      end
      S_TRAP: begin
        pc_src    = TRAP_VECTOR_SEL;
        pc_we     = 1'b1;
        trap      = 1'b1;
        state_nxt = S_FETCH;
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase

    // A stalled access holds its state; only the limit forces a trap.
    if (mem_state && !ready) begin
      state_nxt = wait_timeout ? S_TRAP : state;
    end
  end

  assign wait_clr  = (state_nxt != state);
  assign wait_incr = mem_state & ~ready;

  acc_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_timer (
    .CLK    (CLK),
    .Reset  (Reset),
    .clr    (wait_clr),
    .incr   (wait_incr),
    .timeout(wait_timeout)
  );

  // Enables are gated by Reset so an aborted write is dropped immediately.
  assign PCWrite  = pc_we  & ~Reset;
  assign IRWrite  = ir_we  & ~Reset;
  assign ACCWrite = acc_we & ~Reset;
  assign SPWrite  = sp_we  & ~Reset;
  assign MemWrite = mem_we & ~Reset;
  assign MemRead  = mem_re & ~Reset;

  assign PCSrc    = pc_src;
  assign MemAddr  = mem_addr;
  assign MemData  = mem_data;
  assign ACCSrc   = acc_src;
  assign ALUSrcA  = alu_a;
  assign ALUSrcB  = alu_b;
  assign ALUOp    = alu_op;
  assign Trap     = trap;
  assign Halted   = halted;
  assign StateOut = state;

endmodule

// File: tb/tb_acc_multicycle_ctrl.sv
// Self-checking bench for acc_multicycle_ctrl: directed vector table, corner
// sequences for waits/timeouts/halt/reset, and a randomized reference model run.
module tb_acc_multicycle_ctrl;

  localparam int MAXW = 3;

  localparam logic [4:0] T_FETCH = 5'd0,  T_DECODE = 5'd1,  T_HALT = 5'd2,   T_SAVE = 5'd3,
                         T_LOAD = 5'd4,   T_LOADUI = 5'd5,  T_BNE = 5'd6,    T_BEQ = 5'd7,
                         T_SLT = 5'd8,    T_SLTI = 5'd9,    T_J = 5'd10,     T_JAL = 5'd11,
                         T_ADDR = 5'd12,  T_SW_MEM = 5'd13, T_LW_MEM = 5'd14, T_MS = 5'd15,
                         T_SUB = 5'd16,   T_ADD = 5'd17,    T_ADDI = 5'd18,  T_AND = 5'd19,
                         T_OR = 5'd20,    T_ORI = 5'd21,    T_LOADI = 5'd22, T_TRAP = 5'd23;

  logic       CLK = 1'b0;
  logic       Reset, MemReady, AluZero;
  logic [5:0] Opcode;
  logic [1:0] PCSrc, MemAddr, ALUSrcA;
  logic       PCWrite, IRWrite, ACCWrite, SPWrite, MemWrite, MemRead, MemData, Trap, Halted;
  logic [2:0] ACCSrc, ALUSrcB, ALUOp;
  logic [4:0] StateOut;

  always #5 CLK = ~CLK;

  acc_multicycle_ctrl #(.OPCODE_W(6), .MEM_WAIT_EN(1'b1), .MAX_WAIT(MAXW)) dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .MemReady(MemReady), .AluZero(AluZero),
    .PCSrc(PCSrc), .PCWrite(PCWrite), .IRWrite(IRWrite), .ACCWrite(ACCWrite),
    .SPWrite(SPWrite), .MemWrite(MemWrite), .MemRead(MemRead), .MemAddr(MemAddr),
    .MemData(MemData), .ACCSrc(ACCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .Trap(Trap), .Halted(Halted), .StateOut(StateOut)
  );

  typedef struct packed {
    logic [1:0] pcsrc;
    logic pcw, irw, accw, spw, memw, memr;
    logic [1:0] maddr;
    logic mdata;
    logic [2:0] accsrc;
    logic [1:0] srca;
    logic [2:0] srcb;
    logic [2:0] aluop;
    logic trap, halted;
  } outs_t;

  outs_t act;
  assign act = {PCSrc, PCWrite, IRWrite, ACCWrite, SPWrite, MemWrite, MemRead,
                MemAddr, MemData, ACCSrc, ALUSrcA, ALUSrcB, ALUOp, Trap, Halted};

  typedef struct {
    logic [5:0] op;
    logic rdy, z;
    logic [4:0] st;
    logic pcw, accw;
    logic [1:0] pcsrc;
    logic trap;
  } vec_t;

  vec_t vecs[$];
  int tests = 0, fails = 0;
  logic [4:0] m_state;
  int m_wait;
  logic [5:0] rop;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic logic [4:0] exec_of(input logic [5:0] op);
    case (op)
      6'd0: return T_HALT;    6'd1: return T_SAVE;    6'd2: return T_LOAD;
      6'd3: return T_LOADUI;  6'd4: return T_BNE;     6'd5: return T_BEQ;
      6'd6: return T_SLT;     6'd7: return T_SLTI;    6'd8: return T_J;
      6'd9: return T_JAL;     6'd10: return T_ADDR;   6'd11: return T_ADDR;
      6'd12: return T_MS;     6'd13: return T_SUB;    6'd14: return T_ADD;
      6'd15: return T_ADDI;   6'd16: return T_AND;    6'd17: return T_OR;
      6'd18: return T_ORI;    6'd19: return T_LOADI;
      default: return T_TRAP;
    endcase
  endfunction

  function automatic logic is_mem(input logic [4:0] s);
    return s inside {T_FETCH, T_LOAD, T_SAVE, T_JAL, T_LW_MEM, T_SW_MEM};
  endfunction

  // Per-state output table from the control specification.
  function automatic outs_t expect_out(input logic [4:0] st, input logic rdy, input logic z);
    outs_t o;
    o = '0;
    case (st)
      T_FETCH:  begin o.memr = 1; o.aluop = 3'd2; o.irw = rdy; o.pcw = rdy; end
      T_DECODE: begin o.srcb = 3'd4; o.aluop = 3'd2; end
      T_HALT:   o.halted = 1;
      T_SAVE:   begin o.memw = 1; o.maddr = 2'd1; end
      T_LOAD:   begin o.memr = 1; o.maddr = 2'd1; o.accsrc = 3'd1; o.accw = rdy; end
      T_LOADUI: o.accw = 1;
      T_LOADI:  begin o.accw = 1; o.accsrc = 3'd3; end
      T_BEQ:    begin o.srca = 2'd1; o.srcb = 3'd2; o.aluop = 3'd3; o.pcsrc = 2'd1; o.pcw = z; end
      T_BNE:    begin o.srca = 2'd1; o.srcb = 3'd2; o.aluop = 3'd3; o.pcsrc = 2'd1; o.pcw = ~z; end
      T_J:      begin o.pcw = 1; o.pcsrc = 2'd1; end
      T_JAL:    begin o.memw = 1; o.maddr = 2'd2; o.mdata = 1; o.pcsrc = 2'd1; o.pcw = rdy; end
      T_ADDR:   begin o.srca = 2'd2; o.srcb = 3'd1; o.aluop = 3'd2; end
      T_MS:     begin o.srca = 2'd2; o.srcb = 3'd1; o.aluop = 3'd2; o.spw = 1; end
      T_SW_MEM: begin o.memw = 1; o.maddr = 2'd3; end
      T_LW_MEM: begin o.memr = 1; o.maddr = 2'd3; o.accsrc = 3'd2; o.accw = rdy; end
      T_TRAP:   begin o.pcsrc = 2'd2; o.pcw = 1; o.trap = 1; end
      T_SLT:    begin o.srca = 2'd1; o.accw = 1; o.accsrc = 3'd4; o.srcb = 3'd2; o.aluop = 3'd4; end
      T_SLTI:   begin o.srca = 2'd1; o.accw = 1; o.accsrc = 3'd4; o.srcb = 3'd3; o.aluop = 3'd4; end
      T_SUB:    begin o.srca = 2'd1; o.accw = 1; o.accsrc = 3'd4; o.srcb = 3'd2; o.aluop = 3'd3; end
      T_ADD:    begin o.srca = 2'd1; o.accw = 1; o.accsrc = 3'd4; o.srcb = 3'd2; o.aluop = 3'd2; end
      T_ADDI:   begin o.srca = 2'd1; o.accw = 1; o.accsrc = 3'd4; o.srcb = 3'd1; o.aluop = 3'd2; end
      T_AND:    begin o.srca = 2'd1; o.accw = 1; o.accsrc = 3'd4; o.srcb = 3'd2; o.aluop = 3'd0; end
      T_OR:     begin o.srca = 2'd1; o.accw = 1; o.accsrc = 3'd4; o.srcb = 3'd2; o.aluop = 3'd1; end
      T_ORI:    begin o.srca = 2'd1; o.accw = 1; o.accsrc = 3'd4; o.srcb = 3'd3; o.aluop = 3'd1; end
      default:  ;
    endcase
    return o;
  endfunction

  task automatic check_model(input logic rdy, input logic z);
    chk("model_state", 32'(StateOut), 32'(m_state));
    chk("model_outs", 32'(act), 32'(expect_out(m_state, rdy, z)));
  endtask

  task automatic advance(input logic [5:0] op, input logic rdy);
    logic [4:0] cur;
    cur = m_state;
    if (is_mem(cur) && !rdy) begin
      if (m_wait == MAXW) begin
        m_state = T_TRAP;
        m_wait  = 0;
      end else begin
        m_wait++;
      end
    end else begin
      m_wait = 0;
      case (cur)
        T_FETCH:  m_state = T_DECODE;
        T_DECODE: m_state = exec_of(op);
        T_ADDR:   m_state = (op == 6'd11) ? T_LW_MEM : T_SW_MEM;
        T_HALT:   m_state = T_HALT;
        default:  m_state = T_FETCH;
      endcase
    end
  endtask

  task automatic step(input logic [5:0] op, input logic rdy, input logic z,
                      output logic [4:0] st_seen, output outs_t o_seen);
    Opcode = op; MemReady = rdy; AluZero = z;
    @(negedge CLK);
    st_seen = StateOut;
    o_seen  = act;
    check_model(rdy, z);
    @(posedge CLK); #1;
    advance(op, rdy);
  endtask

  task automatic do_reset();
    outs_t e;
    Reset = 1'b1; MemReady = 1'b1; AluZero = 1'b0; Opcode = '0;
    @(negedge CLK);
    e = expect_out(T_FETCH, 1'b1, 1'b0);
    e.pcw = 0; e.irw = 0; e.memr = 0;
    chk("reset_state", 32'(StateOut), 32'(T_FETCH));
    chk("reset_outs", 32'(act), 32'(e));
    @(posedge CLK); #1;
    Reset = 1'b0;
    m_state = T_FETCH;
    m_wait  = 0;
  endtask

  task automatic add_vec(input logic [5:0] op, input logic rdy, input logic z, input logic [4:0] st,
                         input logic pcw, input logic accw, input logic [1:0] pcsrc, input logic trap);
    vec_t v;
    v.op = op; v.rdy = rdy; v.z = z; v.st = st;
    v.pcw = pcw; v.accw = accw; v.pcsrc = pcsrc; v.trap = trap;
    vecs.push_back(v);
  endtask

  // Three-row instruction: FETCH, DECODE, then the given execute row.
  task automatic add_instr(input logic [5:0] op, input logic z, input logic [4:0] st,
                           input logic pcw, input logic accw, input logic [1:0] pcsrc, input logic trap);
    add_vec(op, 1'b1, z, T_FETCH,  1'b1, 1'b0, 2'd0, 1'b0);
    add_vec(op, 1'b1, z, T_DECODE, 1'b0, 1'b0, 2'd0, 1'b0);
    add_vec(op, 1'b1, z, st, pcw, accw, pcsrc, trap);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] s;
    outs_t o;
    int cnt, pulses;
    logic seen;

    add_instr(6'd14, 1'b0, T_ADD,   1'b0, 1'b1, 2'd0, 1'b0);
    add_instr(6'd5,  1'b1, T_BEQ,   1'b1, 1'b0, 2'd1, 1'b0);
    add_instr(6'd5,  1'b0, T_BEQ,   1'b0, 1'b0, 2'd1, 1'b0);
    add_instr(6'd4,  1'b0, T_BNE,   1'b1, 1'b0, 2'd1, 1'b0);
    add_instr(6'd4,  1'b1, T_BNE,   1'b0, 1'b0, 2'd1, 1'b0);
    add_instr(6'd25, 1'b0, T_TRAP,  1'b1, 1'b0, 2'd2, 1'b1);
    add_instr(6'd8,  1'b0, T_J,     1'b1, 1'b0, 2'd1, 1'b0);
    add_instr(6'd19, 1'b0, T_LOADI, 1'b0, 1'b1, 2'd0, 1'b0);
    add_instr(6'd12, 1'b0, T_MS,    1'b0, 1'b0, 2'd0, 1'b0);
    add_vec(6'd14, 1'b1, 1'b0, T_FETCH, 1'b1, 1'b0, 2'd0, 1'b0);

    do_reset();

    foreach (vecs[i]) begin
      Opcode = vecs[i].op; MemReady = vecs[i].rdy; AluZero = vecs[i].z;
      @(negedge CLK);
      chk("vec_state", 32'(StateOut), 32'(vecs[i].st));
      chk("vec_pcwrite", 32'(PCWrite), 32'(vecs[i].pcw));
      chk("vec_accwrite", 32'(ACCWrite), 32'(vecs[i].accw));
      chk("vec_pcsrc", 32'(PCSrc), 32'(vecs[i].pcsrc));
      chk("vec_trap", 32'(Trap), 32'(vecs[i].trap));
      check_model(vecs[i].rdy, vecs[i].z);
      @(posedge CLK); #1;
      advance(vecs[i].op, vecs[i].rdy);
    end
    // The last table row (FETCH) already advanced into DECODE; finish that ADD.
    step(6'd14, 1'b1, 1'b0, s, o);
    step(6'd14, 1'b1, 1'b0, s, o);

    // LW with three stall cycles in LW_MEM
    step(6'd11, 1'b1, 1'b0, s, o);
    step(6'd11, 1'b1, 1'b0, s, o);
    step(6'd11, 1'b1, 1'b0, s, o);
    chk("lw_addr_state", 32'(s), 32'(T_ADDR));
    cnt = 0; pulses = 0;
    for (int k = 0; k < 4; k++) begin
      step(6'd11, (k == 3), 1'b0, s, o);
      if (s == T_LW_MEM) cnt++;
      if (o.accw) pulses++;
    end
    chk("lw_hold_cycles", 32'(cnt), 32'd4);
    chk("lw_accwrite_pulses", 32'(pulses), 32'd1);

    // SW reaches SW_MEM with MemWrite
    step(6'd10, 1'b1, 1'b0, s, o);
    chk("sw_back_to_fetch", 32'(s), 32'(T_FETCH));
    step(6'd10, 1'b1, 1'b0, s, o);
    step(6'd10, 1'b1, 1'b0, s, o);
    step(6'd10, 1'b1, 1'b0, s, o);
    chk("sw_mem_state", 32'(s), 32'(T_SW_MEM));
    chk("sw_memwrite", 32'(o.memw), 32'd1);

    // FETCH timeout: four not-ready cycles then TRAP, IR never written
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(6'd14, 1'b0, 1'b0, s, o);
      if (o.irw) seen = 1'b1;
    end
    chk("timeout_irwrite_never", 32'(seen), 32'd0);
    step(6'd14, 1'b0, 1'b0, s, o);
    chk("timeout_trap_state", 32'(s), 32'(T_TRAP));
    chk("timeout_trap_pulse", 32'(o.trap), 32'd1);

    // Ready arriving exactly at the limit completes the fetch normally
    for (int k = 0; k < 4; k++) step(6'd14, (k == 3), 1'b0, s, o);
    chk("limit_ready_irwrite", 32'(o.irw), 32'd1);
    step(6'd14, 1'b1, 1'b0, s, o);
    chk("limit_ready_decode", 32'(s), 32'(T_DECODE));
    step(6'd14, 1'b1, 1'b0, s, o);

    // Randomized run against the reference model (HALT excluded here)
    rop = 6'd14;
    for (int i = 0; i < 600; i++) begin
      if (m_state == T_FETCH) rop = 6'($urandom_range(1, 63));
      step(rop, ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), s, o);
    end

    // Drain to FETCH, then HALT is absorbing for 20 cycles
    for (int i = 0; i < 12 && m_state != T_FETCH; i++) step(rop, 1'b1, 1'b0, s, o);
    chk("drain_to_fetch", 32'(m_state), 32'(T_FETCH));
    do_reset();
    step(6'd0, 1'b1, 1'b0, s, o);
    step(6'd0, 1'b1, 1'b0, s, o);
    for (int i = 0; i < 20; i++) begin
      step(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), s, o);
      chk("halt_halted", 32'(o.halted), 32'd1);
      chk("halt_state", 32'(s), 32'(T_HALT));
    end

    // Reset asserted mid-SAVE drops MemWrite immediately
    do_reset();
    step(6'd1, 1'b1, 1'b0, s, o);
    step(6'd1, 1'b1, 1'b0, s, o);
    step(6'd1, 1'b0, 1'b0, s, o);
    chk("save_state", 32'(s), 32'(T_SAVE));
    MemReady = 1'b0;
    #2;
    chk("save_memwrite_held", 32'(MemWrite), 32'd1);
    Reset = 1'b1;
    #1;
    chk("reset_drops_memwrite", 32'(MemWrite), 32'd0);
    chk("reset_forces_fetch", 32'(StateOut), 32'(T_FETCH));
    @(posedge CLK); #1;
    Reset = 1'b0;
    m_state = T_FETCH;
    m_wait  = 0;
    step(6'd14, 1'b1, 1'b0, s, o);
    step(6'd14, 1'b1, 1'b0, s, o);
    chk("after_reset_decode", 32'(s), 32'(T_DECODE));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
